// File: rtl/acl_pkg.sv
// Shared definitions for the PmodACL (ADXL345) command sequencer:
// register map, configuration values, FSM states and the command-word builder.
package acl_pkg;

    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] CFG_DATA_FORMAT  = 8'h00;
    localparam logic [7:0] CFG_POWER_CTL    = 8'h08;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_WAIT_CLR  = 3'd4,
        ST_GAP       = 3'd5,
        ST_PERIOD    = 3'd6
    } acl_state_e;

    // Command word {R/W, MB=0, addr[5:0], data[7:0]} for table entry idx.
    function automatic logic [15:0] acl_cmd(input logic [2:0] idx);
        logic [15:0] cmd;
        case (idx)
            3'd0:    cmd = {1'b0, 1'b0, ADDR_DATA_FORMAT, CFG_DATA_FORMAT};
            3'd1:    cmd = {1'b0, 1'b0, ADDR_POWER_CTL, CFG_POWER_CTL};
            default: cmd = {1'b1, 1'b0, 6'(ADDR_DATAX0 + {3'b000, 3'(idx - 3'd2)}), 8'h00};
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/acl_spi_master.sv
// Sequences ADXL345 register accesses over a 16-bit SPI shifter: two config
// writes after reset, then periodic six-byte bursts assembled into X/Y/Z samples.
module acl_spi_master
    import acl_pkg::*;
#(
    parameter logic [23:0] SAMPLE_PERIOD = 24'd5_000_000,
    parameter logic [7:0]  SS_SETUP      = 8'd100,
    parameter logic [7:0]  SS_GAP        = 8'd100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [7:0]        rxbuffer,
    output logic              transmit,
    output logic [15:0]       txbuffer,
    output logic              ss,
    output logic signed [9:0] x_axis,
    output logic signed [9:0] y_axis,
    output logic signed [9:0] z_axis,
    output logic              data_valid,
    output logic              busy
);

    localparam logic [7:0]  SETUP_LAST = 8'(SS_SETUP - 8'd1);
    localparam logic [7:0]  GAP_LAST   = 8'(SS_GAP - 8'd1);
    localparam logic [23:0] PER_LAST   = 24'(SAMPLE_PERIOD - 24'd1);

    acl_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] per_q, per_d;
    logic [7:0]  rx_q [0:5];
    logic [7:0]  rx_d [0:5];
    logic        transmit_q, transmit_d;
    logic [15:0] txbuffer_q, txbuffer_d;
    logic        ss_q, ss_d;
    logic [9:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        start_burst_s;

    // Next-state, counters, byte capture and output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q + 8'd1;
        per_d         = (per_q != PER_LAST) ? per_q + 24'd1 : per_q;
        rx_d          = rx_q;
        transmit_d    = 1'b0;
        txbuffer_d    = txbuffer_q;
        ss_d          = ss_q;
        x_d           = x_q;
        y_d           = y_q;
        z_d           = z_q;
        data_valid_d  = 1'b0;
        start_burst_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_SETUP;
                ss_d       = 1'b0;
                txbuffer_d = acl_cmd(idx_q);
                cnt_d      = 8'd0;
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d    = ST_PULSE;
                    transmit_d = 1'b1;
                end else begin
                    state_d    = ST_SETUP;
                end
            end
            ST_PULSE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d = ST_WAIT_CLR;
                    if (idx_q >= 3'd2) begin
                        rx_d[3'(idx_q - 3'd2)] = rxbuffer;
                    end else begin
                        rx_d = rx_q;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_CLR: begin
                if (!done) begin
                    state_d = ST_GAP;
                    ss_d    = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_WAIT_CLR;
                end
            end
            ST_GAP: begin
                if (cnt_q != GAP_LAST) begin
                    state_d = ST_GAP;
                end else if (idx_q != 3'd7) begin
                    state_d    = ST_SETUP;
                    idx_d      = idx_q + 3'd1;
                    ss_d       = 1'b0;
                    txbuffer_d = acl_cmd(idx_q + 3'd1);
                    cnt_d      = 8'd0;
                    // The first data read marks the start of the sample period.
                    per_d      = (idx_q == 3'd1) ? 24'd0 : per_d;
                end else begin
                    x_d           = {rx_q[1][1:0], rx_q[0]};
                    y_d           = {rx_q[3][1:0], rx_q[2]};
                    z_d           = {rx_q[5][1:0], rx_q[4]};
                    data_valid_d  = 1'b1;
                    state_d       = ST_PERIOD;
                    start_burst_s = (per_q == PER_LAST);
                end
            end
            ST_PERIOD: begin
                start_burst_s = (per_q == PER_LAST);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An overrunning burst restarts directly from its last gap.
        if (start_burst_s) begin
            state_d    = ST_SETUP;
            idx_d      = 3'd2;
            ss_d       = 1'b0;
            txbuffer_d = acl_cmd(3'd2);
            cnt_d      = 8'd0;
            per_d      = 24'd0;
        end else begin
            per_d      = per_d;
        end

        busy_d = (state_d != ST_PERIOD) && (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= 8'd0;
            per_q        <= 24'd0;
            for (int i = 0; i < 6; i++) begin
                rx_q[i] <= 8'h00;
            end
            transmit_q   <= 1'b0;
            txbuffer_q   <= 16'h0000;
            ss_q         <= 1'b1;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            z_q          <= 10'd0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            per_q        <= per_d;
            rx_q         <= rx_d;
            transmit_q   <= transmit_d;
            txbuffer_q   <= txbuffer_d;
            ss_q         <= ss_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign transmit   = transmit_q;
    assign txbuffer   = txbuffer_q;
    assign ss         = ss_q;
    assign x_axis     = x_q;
    assign y_axis     = y_q;
    assign z_axis     = z_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_acl_spi_master.sv
// Randomized scoreboard bench for acl_spi_master with an ADXL345-like SPI responder.
module tb_acl_spi_master;

    localparam int SP  = 2000;
    localparam int SSU = 100;
    localparam int SSG = 100;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] z;
    } axes_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done_resp = 1'b0;
    logic        done_spur = 1'b0;
    logic        done;
    logic [7:0]  rxbuffer = 8'h00;
    logic        transmit;
    logic [15:0] txbuffer;
    logic        ss;
    logic [9:0]  x_axis, y_axis, z_axis;
    logic        data_valid;
    logic        busy;

    int    checks = 0;
    int    errors = 0;
    int    valid_cnt = 0;
    int    burst_no = 0;
    bit    hit_idx4 = 1'b0;
    axes_t exp_q[$];

    assign done = done_resp | done_spur;

    acl_spi_master #(
        .SAMPLE_PERIOD(24'(SP)),
        .SS_SETUP     (8'(SSU)),
        .SS_GAP       (8'(SSG))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .rxbuffer  (rxbuffer),
        .transmit  (transmit),
        .txbuffer  (txbuffer),
        .ss        (ss),
        .x_axis    (x_axis),
        .y_axis    (y_axis),
        .z_axis    (z_axis),
        .data_valid(data_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // n-th command since reset: two config writes, then reads of 0x32..0x37 repeating.
    function automatic logic [15:0] exp_cmd(input int n);
        logic [7:0] hi;
        if (n == 0) return 16'h3100;
        if (n == 1) return 16'h2D08;
        hi = 8'(8'hB2 + (n - 2) % 6);
        return {hi, 8'h00};
    endfunction

    // Responder: done rises 40 cycles after transmit, held 3 cycles; reads return
    // directed bytes in the first burst, random bytes afterwards.
    initial begin
        int         tcnt;
        int         k;
        logic [15:0] cmd;
        logic [7:0]  b;
        logic [7:0]  regs [6];
        logic [7:0]  dir_bytes [6];
        axes_t       e;
        dir_bytes = '{8'h34, 8'hFE, 8'h12, 8'h01, 8'hFF, 8'h03};
        tcnt = 0;
        cmd  = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tcnt      = 0;
                done_resp = 1'b0;
            end else if (transmit) begin
                tcnt = 1;
                cmd  = txbuffer;
                if (cmd[13:8] == 6'h34 && burst_no >= 2) hit_idx4 = 1'b1;
            end else if (tcnt != 0) begin
                tcnt++;
                if (tcnt == 41) begin
                    done_resp = 1'b1;
                    k = int'(cmd[13:8]) - 'h32;
                    if (cmd[15] && k >= 0 && k < 6) begin
                        b = (burst_no == 0) ? dir_bytes[k] : 8'($urandom_range(0, 255));
                        rxbuffer = b;
                        regs[k]  = b;
                        if (k == 5) begin
                            e.x = 10'((int'(regs[1]) % 4) * 256 + int'(regs[0]));
                            e.y = 10'((int'(regs[3]) % 4) * 256 + int'(regs[2]));
                            e.z = 10'((int'(regs[5]) % 4) * 256 + int'(regs[4]));
                            exp_q.push_back(e);
                            burst_no++;
                        end
                    end else begin
                        rxbuffer = 8'($urandom_range(0, 255));
                    end
                end else if (tcnt == 44) begin
                    done_resp = 1'b0;
                    tcnt      = 0;
                end
            end
        end
    end

    // Monitor: framing/timing of each transaction and scoreboard pop on data_valid.
    initial begin
        int    cyc, n, fall_cyc, rise_cyc, last_valid, pulses;
        bit    prev_ss, in_win, have_rise, have_valid, stable;
        logic [15:0] win_txb;
        axes_t e;
        cyc = 0; n = 0; fall_cyc = 0; rise_cyc = 0; last_valid = 0; pulses = 0;
        prev_ss = 1'b1; in_win = 1'b0; have_rise = 1'b0; have_valid = 1'b0; stable = 1'b1;
        win_txb = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                n = 0; in_win = 1'b0; have_rise = 1'b0; have_valid = 1'b0; prev_ss = 1'b1;
            end else begin
                if (prev_ss && !ss) begin
                    if (have_rise) begin
                        checks++;
                        if (cyc - rise_cyc < SSG) begin
                            errors++;
                            $display("FAIL ss_gap: got %0d cycles required >= %0d", cyc - rise_cyc, SSG);
                        end
                    end
                    win_txb = txbuffer; fall_cyc = cyc; pulses = 0; stable = 1'b1; in_win = 1'b1;
                    check("busy_while_ss_low", 32'(busy), 32'd1);
                end
                if (!ss && txbuffer !== win_txb) stable = 1'b0;
                if (transmit) begin
                    pulses++;
                    check("setup_cycles", 32'(cyc - fall_cyc), 32'(SSU));
                    check("txbuffer_cmd", 32'(txbuffer), 32'(exp_cmd(n)));
                    n++;
                end
                if (!prev_ss && ss && in_win) begin
                    check("one_transmit_per_frame", 32'(pulses), 32'd1);
                    check("txbuffer_stable", 32'(stable), 32'd1);
                    in_win = 1'b0; rise_cyc = cyc; have_rise = 1'b1;
                end
                if (data_valid) begin
                    valid_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_valid: got data_valid required none pending");
                    end else begin
                        e = exp_q.pop_front();
                        check("x_axis", 32'(x_axis), 32'(e.x));
                        check("y_axis", 32'(y_axis), 32'(e.y));
                        check("z_axis", 32'(z_axis), 32'(e.z));
                    end
                    if (have_valid) check("valid_spacing", 32'(cyc - last_valid), 32'(SP));
                    have_valid = 1'b1; last_valid = cyc;
                end
                prev_ss = ss;
            end
        end
    end

    task automatic wait_valid(input int target);
        for (int i = 0; i < 20000 && valid_cnt < target; i++) @(negedge clk);
        check("valid_timeout", 32'(valid_cnt >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, 32'(ss), 32'd1);
        check({tag, "_transmit"}, 32'(transmit), 32'd0);
        check({tag, "_txbuffer"}, 32'(txbuffer), 32'd0);
        check({tag, "_x"}, 32'(x_axis), 32'd0);
        check({tag, "_y"}, 32'(y_axis), 32'd0);
        check({tag, "_z"}, 32'(z_axis), 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [9:0] sx, sy, sz;
        int         saved, base;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        wait_valid(1);
        check("first_x", 32'(x_axis), 32'h234);
        check("first_y", 32'(y_axis), 32'h112);
        check("first_z", 32'(z_axis), 32'h3FF);

        wait_valid(2);
        repeat (5) @(negedge clk);
        check("period_idle_busy", 32'(busy), 32'd0);
        sx = x_axis; sy = y_axis; sz = z_axis; saved = valid_cnt;
        done_spur = 1'b1;
        repeat (3) @(negedge clk);
        done_spur = 1'b0;
        repeat (20) @(negedge clk);
        check("spur_no_valid", 32'(valid_cnt), 32'(saved));
        check("spur_x_hold", 32'(x_axis), 32'(sx));
        check("spur_y_hold", 32'(y_axis), 32'(sy));
        check("spur_z_hold", 32'(z_axis), 32'(sz));
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_ss", 32'(ss), 32'd1);

        for (int i = 0; i < 5000 && !hit_idx4; i++) @(negedge clk);
        check("reached_idx4", 32'(hit_idx4), 32'd1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        hit_idx4 = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = valid_cnt;
        wait_valid(base + 2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
